// File: rtl/mux_scan_pkg.sv
// Shared types and bounds for the scanning channel multiplexer.
package mux_scan_pkg;

  localparam int unsigned MAX_CH = 64;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MAN_OUT  = 2'd1,
    SCAN_OUT = 2'd2
  } state_e;

endpackage

// File: rtl/mux_nto1.sv
// Combinational N-to-1 channel selector; an index past the last channel yields zero.
module mux_nto1
  import mux_scan_pkg::*;
#(
  parameter  int unsigned DATA_W = 8,
  parameter  int unsigned N_CH   = 8,
  localparam int unsigned SEL_W  = $clog2(N_CH)
) (
  input  logic [N_CH*DATA_W-1:0] data_in,
  input  logic [SEL_W-1:0]       idx,
  output logic [DATA_W-1:0]      y
);

  if (N_CH < 2 || N_CH > MAX_CH) begin : g_bad_n_ch
    $error("mux_nto1: N_CH must lie in 2..MAX_CH");
  end

  always_comb begin
    // NOTE: y gets a default before the loop so no path leaves it unassigned,
    // which would otherwise infer a latch.
    y = '0;
    for (int k = 0; k < int'(N_CH); k++) begin
      if (int'(idx) == k) y = data_in[k*DATA_W +: DATA_W];
    end
  end

endmodule

// File: rtl/mux_scan_seq.sv
// Registered N-channel mux with manual capture and channel scan onto a valid/ready stream.
// Optional even parity output out_par when MUX_SCAN_PARITY_EN is defined.
module mux_scan_seq
  import mux_scan_pkg::*;
#(
  parameter  int unsigned DATA_W = 8,
  parameter  int unsigned N_CH   = 8,
  localparam int unsigned SEL_W  = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH*DATA_W-1:0] data_in,
  input  logic [SEL_W-1:0]       sel_in,
  input  logic                   sel_stb,
  input  logic                   start,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      data_out,
  output logic [SEL_W-1:0]       out_sel,
  output logic                   out_valid,
  output logic                   busy,
  output logic                   done,
`ifdef MUX_SCAN_PARITY_EN
  output logic                   out_par,
`endif
  output logic                   sel_err
);

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N_CH - 1);
  localparam logic [SEL_W:0]   N_CH_X   = (SEL_W + 1)'(N_CH);

  state_e            state_q;
  logic [DATA_W-1:0] data_q;
  logic [SEL_W-1:0]  sel_q;
  logic              valid_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  logic [SEL_W-1:0]  mux_idx_d;
  logic [DATA_W-1:0] mux_data;
  logic              sel_ok;
  logic              last_beat;
  logic              load_d;

  // The mux looks one beat ahead: ch0 or sel_in from IDLE, the next channel while scanning.
  always_comb begin
    mux_idx_d = '0;
    if (state_q == IDLE) begin
      if (!start) mux_idx_d = sel_in;
    end else begin
      mux_idx_d = sel_q + SEL_W'(1);
    end
  end

  mux_nto1 #(
    .DATA_W (DATA_W),
    .N_CH   (N_CH)
  ) u_mux (
    .data_in (data_in),
    .idx     (mux_idx_d),
    .y       (mux_data)
  );

  assign sel_ok    = ({1'b0, sel_in} < N_CH_X);
  assign last_beat = (sel_q == LAST_SEL);
  assign load_d    = ((state_q == IDLE) && (start || (sel_stb && sel_ok))) ||
                     ((state_q == SCAN_OUT) && out_ready && !last_beat);

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (load_d) data_q <= mux_data;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= SCAN_OUT;
            sel_q   <= '0;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
          end else if (sel_stb) begin
            if (sel_ok) begin
              state_q <= MAN_OUT;
              sel_q   <= sel_in;
              valid_q <= 1'b1;
              busy_q  <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        MAN_OUT: begin
          if (out_ready) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        SCAN_OUT: begin
          if (out_ready) begin
            if (last_beat) begin
              state_q <= IDLE;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              sel_q <= sel_q + SEL_W'(1);
            end
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef MUX_SCAN_PARITY_EN
  logic par_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         par_q <= 1'b0;
    else if (load_d) par_q <= ^mux_data;
  end

  assign out_par = par_q;
`endif

  assign data_out  = data_q;
  assign out_sel   = sel_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign sel_err   = err_q;

endmodule

// File: tb/tb_mux_scan_seq.sv
// Self-checking bench for mux_scan_seq: directed scenarios plus randomized traffic vs a beat-level model.
module tb_mux_scan_seq;

  localparam int DW = 8;
  localparam int N  = 8;
  localparam int N6 = 6;
  localparam int SW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N*DW-1:0] data_in;
  logic [SW-1:0]   sel_in;
  logic            sel_stb, start, out_ready;
  logic [DW-1:0]   data_out;
  logic [SW-1:0]   out_sel;
  logic            out_valid, busy, done, sel_err;

  logic [N6*DW-1:0] data_in6;
  logic [SW-1:0]    sel_in6;
  logic             sel_stb6, start6, ready6;
  logic [DW-1:0]    data_out6;
  logic [SW-1:0]    out_sel6;
  logic             out_valid6, busy6, done6, sel_err6;

`ifdef MUX_SCAN_PARITY_EN
  logic out_par, out_par6;
`endif

  assign data_in6 = data_in[N6*DW-1:0];

  mux_scan_seq #(.DATA_W(DW), .N_CH(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .sel_in    (sel_in),
    .sel_stb   (sel_stb),
    .start     (start),
    .out_ready (out_ready),
    .data_out  (data_out),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done),
`ifdef MUX_SCAN_PARITY_EN
    .out_par   (out_par),
`endif
    .sel_err   (sel_err)
  );

  mux_scan_seq #(.DATA_W(DW), .N_CH(N6)) dut6 (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in6),
    .sel_in    (sel_in6),
    .sel_stb   (sel_stb6),
    .start     (start6),
    .out_ready (ready6),
    .data_out  (data_out6),
    .out_sel   (out_sel6),
    .out_valid (out_valid6),
    .busy      (busy6),
    .done      (done6),
`ifdef MUX_SCAN_PARITY_EN
    .out_par   (out_par6),
`endif
    .sel_err   (sel_err6)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Beat-level reference: what the consumer should see after each clock edge.
  bit         m_busy, m_scan, m_valid, m_done, m_err;
  int         m_sel;
  logic [7:0] m_data;

  function automatic logic [7:0] chan(input int k);
    return data_in[k*DW +: DW];
  endfunction

  task automatic model_reset();
    m_busy = 0; m_scan = 0; m_valid = 0; m_done = 0; m_err = 0;
    m_sel = 0; m_data = 8'h00;
  endtask

  task automatic model_step();
    m_done = 0;
    m_err  = 0;
    if (!m_busy) begin
      if (start) begin
        m_busy = 1; m_scan = 1; m_valid = 1; m_sel = 0; m_data = chan(0);
      end else if (sel_stb) begin
        if (int'(sel_in) < N) begin
          m_busy = 1; m_scan = 0; m_valid = 1; m_sel = int'(sel_in); m_data = chan(m_sel);
        end else begin
          m_err = 1;
        end
      end
    end else if (out_ready) begin
      if (m_scan && m_sel < N - 1) begin
        m_sel  = m_sel + 1;
        m_data = chan(m_sel);
      end else begin
        m_busy = 0; m_valid = 0;
        m_done = m_scan;
        m_scan = 0;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".data_out"},  32'(data_out),  32'(m_data));
    check({tag, ".out_sel"},   32'(out_sel),   32'(m_sel));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
    check({tag, ".busy"},      32'(busy),      32'(m_busy));
    check({tag, ".done"},      32'(done),      32'(m_done));
    check({tag, ".sel_err"},   32'(sel_err),   32'(m_err));
`ifdef MUX_SCAN_PARITY_EN
    check({tag, ".out_par"},   32'(out_par),   32'(^m_data));
`endif
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    compare_all(tag);
  endtask

  task automatic set_default_ch();
    for (int k = 0; k < N; k++) data_in[k*DW +: DW] = 8'hA0 + 8'(k);
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;

    set_default_ch();
    sel_in = '0; sel_stb = 0; start = 0; out_ready = 0;
    sel_in6 = '0; sel_stb6 = 0; start6 = 0; ready6 = 0;
    model_reset();

    // Reset state
    #12;
    compare_all("reset");
    check("reset.valid6", 32'(out_valid6), 0);
    rst = 1'b0;

    // 1. Manual capture of channel 3
    out_ready = 1; sel_in = 3'd3; sel_stb = 1;
    cycle("t1a");
    check("t1.valid", 32'(out_valid), 1);
    check("t1.data",  32'(data_out), 'hA3);
    check("t1.sel",   32'(out_sel), 3);
    sel_stb = 0;
    cycle("t1b");
    check("t1.valid_off", 32'(out_valid), 0);

    // 2. Full scan with continuous ready
    start = 1;
    cycle("t2s");
    start = 0;
    busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < N; i++) begin
      check("t2.data",  32'(data_out), 32'('hA0 + i));
      check("t2.sel",   32'(out_sel), 32'(i));
      check("t2.valid", 32'(out_valid), 1);
      busy_cnt += int'(busy);
      cycle("t2");
      done_cnt += int'(done);
    end
    check("t2.done_cnt", 32'(done_cnt), 1);
    check("t2.busy_cnt", 32'(busy_cnt), 8);
    check("t2.valid_end", 32'(out_valid), 0);
    cycle("t2e");
    check("t2.done_once", 32'(done), 0);

    // 3. Backpressure holding beat 2 while its source changes
    start = 1;
    cycle("t3s");
    start = 0;
    cycle("t3");
    cycle("t3");
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) data_in[2*DW +: DW] = 8'h55;
      cycle("t3h");
      check("t3.hold_data", 32'(data_out), 'hA2);
      check("t3.hold_sel",  32'(out_sel), 2);
    end
    out_ready = 1;
    for (int i = 3; i < N; i++) begin
      cycle("t3r");
      check("t3.resume", 32'(data_out), 32'('hA0 + i));
    end
    cycle("t3e");
    check("t3.done", 32'(done), 1);
    set_default_ch();

    // 4a. Out-of-range select on the six-channel build
    sel_in6 = 3'd7; sel_stb6 = 1;
    cycle("t4");
    check("t4.err7",   32'(sel_err6), 1);
    check("t4.valid7", 32'(out_valid6), 0);
    sel_stb6 = 0;
    cycle("t4");
    check("t4.err_pulse", 32'(sel_err6), 0);
    sel_in6 = 3'd6; sel_stb6 = 1;
    cycle("t4");
    check("t4.err6",  32'(sel_err6), 1);
    check("t4.busy6", 32'(busy6), 0);
    sel_in6 = 3'd5;
    cycle("t4");
    check("t4.err5",   32'(sel_err6), 0);
    check("t4.valid5", 32'(out_valid6), 1);
    check("t4.data5",  32'(data_out6), 'hA5);
    check("t4.sel5",   32'(out_sel6), 5);
    sel_stb6 = 0; ready6 = 1;
    cycle("t4");
    check("t4.accept5", 32'(out_valid6), 0);
    check("t4.done6",   32'(done6), 0);

    // 4b. Start requests during a scan are ignored
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      start = (i < 3);
      cycle("t4s");
      done_cnt += int'(done);
    end
    start = 0;
    check("t4.one_done", 32'(done_cnt), 1);
    check("t4.idle", 32'(busy), 0);

    // 5. Asynchronous reset mid-scan
    start = 1;
    cycle("t5s");
    start = 0;
    for (int i = 0; i < 4; i++) cycle("t5");
    check("t5.at_beat4", 32'(out_sel), 4);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all("t5.async");
    @(posedge clk);
    #1;
    compare_all("t5.held");
    #2;
    rst = 1'b0;
    start = 1;
    cycle("t5r");
    start = 0;
    check("t5.restart_data", 32'(data_out), 'hA0);
    check("t5.restart_sel",  32'(out_sel), 0);
    done_cnt = 0;
    for (int i = 0; i < N; i++) begin
      cycle("t5c");
      done_cnt += int'(done);
    end
    check("t5.done_after", 32'(done_cnt), 1);

`ifdef MUX_SCAN_PARITY_EN
    // 6. Even parity follows the captured data
    data_in[0 +: DW]  = 8'h07;
    data_in[DW +: DW] = 8'h03;
    start = 1;
    cycle("t6s");
    start = 0;
    check("t6.par07", 32'(out_par), 1);
    cycle("t6");
    check("t6.par03", 32'(out_par), 0);
    for (int i = 0; i < N; i++) cycle("t6f");
    set_default_ch();
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      start     = ($urandom_range(0, 9) == 0);
      sel_stb   = ($urandom_range(0, 3) == 0);
      sel_in    = SW'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0) data_in = {$urandom(), $urandom()};
      cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
